// File: rtl/div_result_bcd.sv
// Result stage for the 4-bit divider: captures quotient/remainder/divisor and
// converts quotient and remainder to two-digit BCD by shift-add-3 over 5 cycles.
module div_result_bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] q,
    input  logic [4:0] r,
    input  logic [3:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] q_tens,
    output logic [3:0] q_ones,
    output logic [3:0] r_tens,
    output logic [3:0] r_ones,
    output logic       div_by_zero,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready/out_valid depend only on the state register, and a
    // producer holds its data stable until the transfer edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BLANK = 4'hF;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [12:0] qsr_q, qsr_d;
    logic [12:0] rsr_q, rsr_d;
    logic [3:0]  q_tens_q, q_tens_d;
    logic [3:0]  q_ones_q, q_ones_d;
    logic [3:0]  r_tens_q, r_tens_d;
    logic [3:0]  r_ones_q, r_ones_d;
    logic        dbz_q, dbz_d;
    logic [12:0] qsr_nxt, rsr_nxt;

    // One double-dabble step on {tens[12:9], ones[8:5], bin[4:0]}.
    function automatic logic [12:0] dd_step(input logic [12:0] v);
        logic [3:0]  t;
        logic [3:0]  o;
        logic [12:0] w;
        t = v[12:9];
        o = v[8:5];
        if (o >= 4'd5) o = o + 4'd3;
        if (t >= 4'd5) t = t + 4'd3;
        w = {t, o, v[4:0]};
        return {w[11:0], 1'b0};
    endfunction

    assign qsr_nxt = dd_step(qsr_q);
    assign rsr_nxt = dd_step(rsr_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qsr_d    = qsr_q;
        rsr_d    = rsr_q;
        q_tens_d = q_tens_q;
        q_ones_d = q_ones_q;
        r_tens_d = r_tens_q;
        r_ones_d = r_ones_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (y == 4'd0) begin
                        q_tens_d = BLANK;
                        q_ones_d = BLANK;
                        r_tens_d = BLANK;
                        r_ones_d = BLANK;
                        dbz_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        qsr_d   = {8'b0, 1'b0, q};
                        rsr_d   = {8'b0, r};
                        cnt_d   = 3'd0;
                        dbz_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                qsr_d = qsr_nxt;
                rsr_d = rsr_nxt;
                if (cnt_q == 3'd4) begin
                    q_tens_d = qsr_nxt[12:9];
                    q_ones_d = qsr_nxt[8:5];
                    r_tens_d = rsr_nxt[12:9];
                    r_ones_d = rsr_nxt[8:5];
                    cnt_d    = 3'd0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            qsr_q    <= 13'd0;
            rsr_q    <= 13'd0;
            q_tens_q <= 4'h0;
            q_ones_q <= 4'h0;
            r_tens_q <= 4'h0;
            r_ones_q <= 4'h0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qsr_q    <= qsr_d;
            rsr_q    <= rsr_d;
            q_tens_q <= q_tens_d;
            q_ones_q <= q_ones_d;
            r_tens_q <= r_tens_d;
            r_ones_q <= r_ones_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign q_tens      = q_tens_q;
    assign q_ones      = q_ones_q;
    assign r_tens      = r_tens_q;
    assign r_ones      = r_ones_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
